pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four hazard sources into one set of per-stage write enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers: data-memory wait, multi-cycle divide, load-use, and taken branch.
- Owns a small FSM and a divide cycle counter.
- Sits beside the datapath; all control outputs are combinational from state plus current-cycle inputs.

Parameters:
DIV_CYCLES, 32, cycles EX is occupied by a divide (minimum 2); counter width is $clog2(DIV_CYCLES).

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
idExMemRead  input  1  instruction in EX is a load
idExRegWriteAddr  input  5  destination register of instruction in EX
ifIdRs  input  5  rs of instruction in ID
ifIdRt  input  5  rt of instruction in ID
ifIdUsesRt  input  1  ID instruction reads rt as a source
branchTaken  input  1  branch/jump in ID resolved taken
divStart  input  1  instruction in EX is div/divu
memReq  input  1  MEM-stage data access active
memReady  input  1  data memory completes access this cycle
pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite  output  1 each  stage register enables
ifIdFlush, idExFlush, exMemFlush  output  1 each  load bubble (NOP) into that register
divBusy  output  1  FSM in DIV state
divDone  output  1  divide release cycle
stallCycles  output  32  count of cycles with pcWrite==0

Behaviour:
- States: RUN, DIV, MEM. Reset -> RUN, divide counter 0, stallCycles 0.
- While reset is high: all write enables and flushes 0; divBusy, divDone 0.
- Default (no hazard): all enables 1, all flushes 0.
- Load-use hit: idExMemRead && idExRegWriteAddr!=0 && (idExRegWriteAddr==ifIdRs || (ifIdUsesRt && idExRegWriteAddr==ifIdRt)). Register $zero never stalls.
- RUN priority (highest first):
  1. memReq && !memReady: all five enables 0, no flushes; next state MEM.
  2. divStart: pcWrite, ifIdWrite, idExWrite = 0; exMemFlush = 1; counter <= DIV_CYCLES-1; next state DIV.
  3. Load-use hit: pcWrite = 0, ifIdWrite = 0, idExFlush = 1; exactly one bubble.
  4. branchTaken: ifIdFlush = 1.
  A higher item suppresses all lower ones. For example, load-use with branchTaken gives no ifIdFlush; the branch re-resolves next cycle.
- MEM state: all enables 0 while !memReady.
  - memReady=1: release in the same cycle. Enables follow the RUN rules with rule 1 skipped; next state RUN.
- DIV state, counter != 0:
  - pcWrite, ifIdWrite, idExWrite = 0; exMemFlush = 1; memWbWrite = 1.
  - Counter decrements each cycle; divBusy = 1.
  - divStart, branchTaken, load-use and memReq are all ignored.
- DIV state, counter == 0 (release):
  - divDone = 1, divBusy = 1.
  - Enables follow RUN rules 3-4 only; divStart and memReq are ignored.
  - Next state RUN.
- Divide latency: EX frozen for exactly DIV_CYCLES cycles (start cycle plus DIV_CYCLES-1 DIV cycles). The quotient advances into EX/MEM on cycle DIV_CYCLES+1 counted from the start cycle.
- Memory stall has priority over divide start: divStart held during MEM wait is taken on the memReady cycle.
- stallCycles: +1 on each cycle pcWrite==0 with reset low; saturates at 32'hFFFFFFFF.
- Reset mid-DIV or mid-MEM: immediate return to RUN; counter cleared; no divDone pulse.

Test Plan:
- Load-use: lw $8 in EX (idExMemRead=1, rd=8), ID rs=8 -> one cycle of pcWrite=0, ifIdWrite=0, idExFlush=1; next cycle all enables 1.
- Zero register: rd=0, rs=0, idExMemRead=1 -> no stall. rd=9, rt=9, ifIdUsesRt=0 -> no stall.
- Divide: DIV_CYCLES=4, divStart pulse held in EX -> idExWrite=0 for 4 cycles, divDone=1 on 4th DIV cycle, then RUN; stallCycles=4.
- Memory wait: memReq=1, memReady=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, all 1 on the 4th; stallCycles=3.
- Priority: load-use and branchTaken together -> idExFlush=1, ifIdFlush=0. memReq wait with divStart -> no DIV entry until the memReady cycle.
- Reset asserted asynchronously in DIV with counter=2 -> outputs 0 immediately; after release state RUN, divBusy=0, stallCycles=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges data-memory wait, multi-cycle divide, load-use and taken-branch
// hazards into per-stage register enables and bubble-insert flushes.
// Every control output is combinational from the current state plus
// this cycle's hazard inputs. Only the state, the divide counter and the
// stall counter are registered.
module pipeline_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        idExMemRead,
   input  logic [4:0]  idExRegWriteAddr,
   input  logic [4:0]  ifIdRs,
   input  logic [4:0]  ifIdRt,
   input  logic        ifIdUsesRt,
   input  logic        branchTaken,
   input  logic        divStart,
   input  logic        memReq,
   input  logic        memReady,
   output logic        pcWrite,
   output logic        ifIdWrite,
   output logic        idExWrite,
   output logic        exMemWrite,
   output logic        memWbWrite,
   output logic        ifIdFlush,
   output logic        idExFlush,
   output logic        exMemFlush,
   output logic        divBusy,
   output logic        divDone,
   output logic [31:0] stallCycles,
   output logic [1:0]  dbgState
);

   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

   localparam logic [1:0] RUN = 2'd0;
   localparam logic [1:0] DIV = 2'd1;
   localparam logic [1:0] MEM = 2'd2;

   logic [1:0]    state, stateNext;
   logic [CW-1:0] divCount, divCountNext;
   logic          loadUse;
   logic          allowDiv;   // divide start may be taken this cycle
   logic          allowHaz;   // load-use / branch rules may be applied this cycle

   // $zero is never a real producer, so it can never cause a load-use stall.
   assign loadUse = idExMemRead && (idExRegWriteAddr != 5'd0) &&
                    ((idExRegWriteAddr == ifIdRs) ||
                     (ifIdUsesRt && (idExRegWriteAddr == ifIdRt)));

   assign divBusy  = !reset && (state == DIV);
   assign divDone  = !reset && (state == DIV) && (divCount == '0);
   assign dbgState = state;

   // Hazard merge: pick the state-specific hold first, then fall through the
   // lower-priority rules that this state still honours.
   always_comb begin
      pcWrite      = 1'b1;
      ifIdWrite    = 1'b1;
      idExWrite    = 1'b1;
      exMemWrite   = 1'b1;
      memWbWrite   = 1'b1;
      ifIdFlush    = 1'b0;
      idExFlush    = 1'b0;
      exMemFlush   = 1'b0;
      stateNext    = state;
      divCountNext = divCount;
      allowDiv     = 1'b0;
      allowHaz     = 1'b0;

      if (reset) begin
         pcWrite    = 1'b0;
         ifIdWrite  = 1'b0;
         idExWrite  = 1'b0;
         exMemWrite = 1'b0;
         memWbWrite = 1'b0;
         stateNext  = RUN;
      end else begin
         case (state)
            RUN: begin
               if (memReq && !memReady) begin
                  pcWrite    = 1'b0;
                  ifIdWrite  = 1'b0;
                  idExWrite  = 1'b0;
                  exMemWrite = 1'b0;
                  memWbWrite = 1'b0;
                  stateNext  = MEM;
               end else begin
                  allowDiv = 1'b1;
                  allowHaz = 1'b1;
               end
            end
            MEM: begin
               if (!memReady) begin
                  pcWrite    = 1'b0;
                  ifIdWrite  = 1'b0;
                  idExWrite  = 1'b0;
                  exMemWrite = 1'b0;
                  memWbWrite = 1'b0;
               end else begin
                  // Release in the same cycle; a pending divide is taken here.
                  stateNext = RUN;
                  allowDiv  = 1'b1;
                  allowHaz  = 1'b1;
               end
            end
            DIV: begin
               if (divCount != '0) begin
                  // EX stays frozen; a bubble trails into EX/MEM while older
                  // instructions drain through MEM/WB.
                  pcWrite      = 1'b0;
                  ifIdWrite    = 1'b0;
                  idExWrite    = 1'b0;
                  exMemFlush   = 1'b1;
                  divCountNext = divCount - CW'(1);
               end else begin
                  // Release: the quotient moves into EX/MEM this cycle.
                  stateNext = RUN;
                  allowHaz  = 1'b1;
               end
            end
            default: begin
               stateNext = RUN;
            end
         endcase

         if (allowDiv && divStart) begin
            pcWrite      = 1'b0;
            ifIdWrite    = 1'b0;
            idExWrite    = 1'b0;
            exMemFlush   = 1'b1;
            divCountNext = DIV_LOAD;
            stateNext    = DIV;
         end else if (allowHaz && loadUse) begin
            // One bubble; a taken branch in ID re-resolves next cycle.
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
         end else if (allowHaz && branchTaken) begin
            ifIdFlush = 1'b1;
         end
      end
   end

   // State and divide counter; reset aborts any divide or memory wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         divCount <= '0;
      end else begin
         state    <= stateNext;
         divCount <= divCountNext;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCycles <= 32'd0;
      end else if (!pcWrite && (stallCycles != 32'hFFFF_FFFF)) begin
         stallCycles <= stallCycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: single-cycle hazard vectors from a table, then
// hand-written divide, memory-wait, priority and async-reset sequences.
module tb_pipeline_ctrl;

  localparam int DIVC = 4;
  // Output word order: pc, ifId, idEx, exMem, memWb, ifIdF, idExF, exMemF, busy, done
  localparam logic [9:0] ALL1   = 10'b11111_000_00;
  localparam logic [9:0] ZERO   = 10'b00000_000_00;
  localparam logic [9:0] LDUSE  = 10'b00111_010_00;
  localparam logic [9:0] BRFL   = 10'b11111_100_00;
  localparam logic [9:0] DSTART = 10'b00011_001_00;
  localparam logic [9:0] DHOLD  = 10'b00011_001_10;
  localparam logic [9:0] DREL   = 10'b11111_000_11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        idExMemRead = 1'b0;
  logic [4:0]  idExRegWriteAddr = 5'd0;
  logic [4:0]  ifIdRs = 5'd0;
  logic [4:0]  ifIdRt = 5'd0;
  logic        ifIdUsesRt = 1'b0;
  logic        branchTaken = 1'b0;
  logic        divStart = 1'b0;
  logic        memReq = 1'b0;
  logic        memReady = 1'b0;
  logic        pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite;
  logic        ifIdFlush, idExFlush, exMemFlush, divBusy, divDone;
  logic [31:0] stallCycles;
  logic [1:0]  dbgState;
  logic [9:0]  outVec;

  int nVec = 0;
  int nMis = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    logic       memRead;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       br;
    logic       mReq;
    logic       mRdy;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[11];

  pipeline_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset),
    .idExMemRead(idExMemRead), .idExRegWriteAddr(idExRegWriteAddr),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
    .branchTaken(branchTaken), .divStart(divStart),
    .memReq(memReq), .memReady(memReady),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExWrite(idExWrite),
    .exMemWrite(exMemWrite), .memWbWrite(memWbWrite),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .exMemFlush(exMemFlush),
    .divBusy(divBusy), .divDone(divDone),
    .stallCycles(stallCycles), .dbgState(dbgState)
  );

  assign outVec = {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
                   ifIdFlush, idExFlush, exMemFlush, divBusy, divDone};

  // clock
  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic br,
                       input logic ds, input logic mq, input logic my);
    idExMemRead = mr; idExRegWriteAddr = rd; ifIdRs = rs; ifIdRt = rt;
    ifIdUsesRt = ur; branchTaken = br; divStart = ds; memReq = mq; memReady = my;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input logic [9:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic pop_compare();
    logic [9:0] e;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    nVec++;
    if (outVec !== e) begin
      nMis++;
      $display("FAIL %s: got %b want %b", nm, outVec, e);
    end
  endtask

  // Compare at the falling edge, away from the active edge.
  task automatic sample();
    @(negedge clk);
    pop_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] e);
    nVec++;
    if (act !== e) begin
      nMis++;
      $display("FAIL %s: got %0d want %0d", nm, act, e);
    end
  endtask

  task automatic cycle(input logic [9:0] e, input string nm);
    expect_out(e, nm);
    sample();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    expect_out(ZERO, "in_reset");
    sample();
    check_val("reset_stall", stallCycles, 32'd0);
    check_val("reset_state", {30'd0, dbgState}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int expStall;

    tbl[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, ALL1};   // idle
    tbl[1]  = '{1'b1, 5'd8,  5'd8,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, LDUSE};  // load-use on rs
    tbl[2]  = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LDUSE};  // load-use on rt
    tbl[3]  = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, ALL1};   // rt not a source
    tbl[4]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, ALL1};   // $zero
    tbl[5]  = '{1'b0, 5'd8,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, ALL1};   // not a load
    tbl[6]  = '{1'b0, 5'd0,  5'd4,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, BRFL};   // branch
    tbl[7]  = '{1'b1, 5'd8,  5'd8,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, LDUSE};  // load-use beats branch
    tbl[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, ALL1};   // mem ready at once
    tbl[9]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, BRFL};   // mem ready + branch
    tbl[10] = '{1'b1, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, LDUSE};  // top register

    do_reset();

    // Table vectors, one RUN cycle each.
    expStall = 0;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].memRead, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].usesRt,
            tbl[i].br, 1'b0, tbl[i].mReq, tbl[i].mRdy);
      if (tbl[i].exp[9] == 1'b0) expStall++;
      cycle(tbl[i].exp, $sformatf("vec%0d", i));
    end
    idle();
    cycle(ALL1, "after_table");
    check_val("table_stall", stallCycles, expStall);

    // Load-use: one bubble, then the load has moved on.
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(LDUSE, "lu_bubble");
    drive(1'b0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(ALL1, "lu_next");

    // Divide: start + DIVC-1 hold cycles, then release.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(DSTART, "div_start");
    cycle(DHOLD, "div_hold3");
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // all ignored
    cycle(DHOLD, "div_hold2");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(DHOLD, "div_hold1");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // divStart/memReq ignored
    cycle(DREL, "div_release");
    idle();
    cycle(ALL1, "div_after");
    check_val("div_stall", stallCycles, 32'd4);
    check_val("div_state", {30'd0, dbgState}, 32'd0);

    // Memory wait: three held cycles, release on memReady.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(ZERO, $sformatf("mem_wait%0d", i));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(ALL1, "mem_release");
    idle();
    cycle(ALL1, "mem_after");
    check_val("mem_stall", stallCycles, 32'd3);

    // Memory wait beats divStart; the divide is taken on memReady.
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(ZERO, "md_wait0");
    check_val("md_state_mem", {30'd0, dbgState}, 32'd2);
    cycle(ZERO, "md_wait1");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(DSTART, "md_div_start");
    idle();
    cycle(DHOLD, "md_hold3");
    check_val("md_state_div", {30'd0, dbgState}, 32'd1);

    // Async reset while in DIV with counter at 2.
    reset = 1'b1;
    #1;
    expect_out(ZERO, "async_reset");
    pop_compare();
    check_val("async_state", {30'd0, dbgState}, 32'd0);
    check_val("async_stall", stallCycles, 32'd0);
    tick();
    reset = 1'b0;
    cycle(ALL1, "post_reset");
    check_val("post_state", {30'd0, dbgState}, 32'd0);
    check_val("post_stall", stallCycles, 32'd0);

    if (exp_q.size() != 0) begin
      nVec++;
      nMis++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
